// File: rtl/pipeline_fetch_queue.sv
// pipeline_fetch_queue
// ---------------------------------------------------------------------------
// Consumer side of the fetch PC register. Issues one instruction-memory read
// per PC, captures {instruction, pc} into a small in-order queue for decode,
// and drives stall back to the PC register so the PC advances exactly once
// per accepted fetch, or immediately on a redirect.
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode (same cycle) when the queue is empty and decode is ready.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   pc                  current fetch PC from the PC register
//   stall               1 = hold PC register, 0 = PC register advances
//   mispredict_br_en    redirect/flush (same pulse the PC register consumes)
//   imem_addr           read address (holds its last value while idle)
//   imem_rmask          4'hF = request this cycle, 4'h0 = no request
//   imem_rdata          read data, valid with imem_resp
//   imem_resp           one-cycle pulse per request
//   inst_valid          queue head valid
//   inst, inst_pc       queue head instruction and its PC
//   decode_ready        decode accepts the head this cycle
//   state_dbg           FSM state: 0 = IDLE, 1 = WAIT, 2 = DISCARD
//   count_dbg           queue occupancy
//
// Handshake: the decode transfer happens in a cycle where inst_valid and
// decode_ready are both high and mispredict_br_en is low; inst/inst_pc are
// stable while inst_valid is high and decode_ready is low. A memory request
// is a single cycle with imem_rmask = 4'hF; exactly one imem_resp pulse
// answers it, at the earliest one cycle later.
// ---------------------------------------------------------------------------
module pipeline_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc,
    output logic                     stall,
    input  logic                     mispredict_br_en,
    output logic [31:0]              imem_addr,
    output logic [3:0]               imem_rmask,
    input  logic [31:0]              imem_rdata,
    input  logic                     imem_resp,
    output logic                     inst_valid,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc,
    input  logic                     decode_ready,
    output logic [1:0]               state_dbg,
    output logic [$clog2(DEPTH):0]   count_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [31:0]     q_inst [DEPTH];
    logic [31:0]     q_pc   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     addr_q;

    logic req;       // request issued this cycle
    logic accept;    // kept response arrives this cycle
    logic byp;       // accepted response forwarded directly to decode
    logic wr_en;
    logic pop;
    logic q_valid;

    assign q_valid = (count != '0);

    // A request is only issued with free space, so the later push can never
    // overflow: in WAIT the queue can only drain.
    assign req    = (state == S_IDLE) && (count < FULL) && !mispredict_br_en && !rst;
    assign accept = (state == S_WAIT) && imem_resp && !mispredict_br_en && !rst;

`ifdef FETCH_BYPASS_EN
    assign byp = accept && !q_valid && decode_ready;
`else
    assign byp = 1'b0;
`endif

    assign wr_en = accept && !byp;
    assign pop   = q_valid && decode_ready && !mispredict_br_en;

    // PC register moves on an accepted fetch or takes the redirect.
    assign stall      = rst || !(accept || mispredict_br_en);
    assign imem_rmask = req ? 4'hF : 4'h0;
    assign imem_addr  = req ? pc : addr_q;
    assign inst_valid = !rst && (q_valid || byp);
    assign state_dbg  = state;
    assign count_dbg  = count;

    always_comb begin
        inst    = '0;
        inst_pc = '0;
        if (byp) begin
            inst    = imem_rdata;
            inst_pc = pc;
        end else if (q_valid && !rst) begin
            inst    = q_inst[rd_ptr];
            inst_pc = q_pc[rd_ptr];
        end
    end

    // Next-state logic. A response always ends the outstanding request, even
    // when a flush arrives in the same cycle (the data is simply dropped).
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (req) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp)             state_d = S_IDLE;
                else if (mispredict_br_en) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                if (imem_resp) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr_q <= '0;
        end else begin
            state <= state_d;
            if (req) addr_q <= pc;
            if (mispredict_br_en) begin
                // Flush wins over any push or pop in the same cycle.
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (pop)   rd_ptr <= rd_ptr + AW'(1);
                case ({wr_en, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= pc;
        end
    end

endmodule
